// File: rtl/zet_int_sched.sv
`timescale 1ns/1ps
// zet_int_sched: picks DIV/TRAP/NMI/IRQ service entry at instruction boundaries
// and runs the INTA/vector handshake with the PIC. Macro ZET_NMI_MASK_EN enables NMI nesting mask.
//
// state | meaning
// IDLE  | waiting for div_exc or an instruction boundary
// ACK   | inta driven to the PIC for one cycle
// VWAIT | waiting for vec_vld, timeout down-counter running
// RUN   | service sequence executing, sel/vector held until end_seq

module zet_int_sched #(
   parameter int unsigned VEC_TMO = 15,
   parameter logic [7:0]  DEF_VEC = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       exec_st,
   input  logic       end_seq,
   input  logic       block,
   input  logic       rep,
   input  logic       div_exc,
   input  logic       tflm,
   input  logic       iflm,
   input  logic       iflss,
   input  logic       intr,
   input  logic       nmir,
   input  logic       iret,
   input  logic       vec_vld,
   input  logic [7:0] vec_in,
   output logic [2:0] sel,
   output logic [7:0] vector,
   output logic       inta,
   output logic       nmia,
   output logic       busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_VWAIT, ST_RUN} state_t;

   localparam logic [4:0] TMO_LD = 5'(VEC_TMO);

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [2:0]  sel_q, sel_d;
   logic [7:0]  vector_q, vector_d;
   logic        nmia_q, nmia_d;
   logic        div_pend_q, div_pend_d;
   logic        nmi_mask_q, nmi_mask_d;
   logic        boundary, take_trap, take_nmi, take_irq, nmi_set;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sel_d      = sel_q;
      vector_d   = vector_q;
      nmia_d     = 1'b0;
      div_pend_d = div_pend_q;
      nmi_set    = 1'b0;
      boundary   = exec_st & end_seq;
      take_trap  = tflm & iflss;
      take_nmi   = nmir & iflss & ~nmi_mask_q;
      take_irq   = intr & iflm & iflss;

      if (block) begin
         nmia_d = nmia_q;
         // a divide fault raised under a stall is remembered and served on release
         if (state_q == ST_IDLE && div_exc) div_pend_d = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               div_pend_d = 1'b0;
               if (div_exc || div_pend_q) begin
                  state_d  = ST_RUN;
                  sel_d    = 3'd1;
                  vector_d = 8'd0;
               end else if (boundary) begin
                  if (take_trap) begin
                     state_d  = ST_RUN;
                     sel_d    = 3'd2;
                     vector_d = 8'd1;
                  end else if (take_nmi) begin
                     state_d  = ST_RUN;
                     sel_d    = 3'd3;
                     vector_d = 8'd2;
                     nmia_d   = 1'b1;
                     nmi_set  = 1'b1;
                  end else if (take_irq) begin
                     state_d  = ST_ACK;
                     sel_d    = rep ? 3'd5 : 3'd4;
                  end
               end
            end
            ST_ACK: begin
               state_d = ST_VWAIT;
               cnt_d   = TMO_LD;
            end
            ST_VWAIT: begin
               if (vec_vld) begin
                  state_d  = ST_RUN;
                  vector_d = vec_in;
               end else if (cnt_q == 5'd1) begin
                  state_d  = ST_RUN;
                  vector_d = DEF_VEC;
                  cnt_d    = 5'd0;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            ST_RUN: begin
               if (end_seq) begin
                  state_d = ST_IDLE;
                  sel_d   = 3'd0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

`ifdef ZET_NMI_MASK_EN
   always_comb begin
      nmi_mask_d = nmi_mask_q;
      if (!block) begin
         if (nmi_set)   nmi_mask_d = 1'b1;
         else if (iret) nmi_mask_d = 1'b0;
      end
   end
`else
   logic unused_mask_in;
   assign nmi_mask_d     = 1'b0;
   assign unused_mask_in = &{1'b0, iret, nmi_set};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 5'd0;
         sel_q      <= 3'd0;
         vector_q   <= 8'd0;
         nmia_q     <= 1'b0;
         div_pend_q <= 1'b0;
         nmi_mask_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         vector_q   <= vector_d;
         nmia_q     <= nmia_d;
         div_pend_q <= div_pend_d;
         nmi_mask_q <= nmi_mask_d;
      end
   end

   assign sel    = sel_q;
   assign vector = vector_q;
   assign inta   = (state_q == ST_ACK) & ~block;
   assign nmia   = nmia_q & ~block;
   assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_zet_int_sched.sv
`timescale 1ns/1ps
// Bench for zet_int_sched: directed scenarios plus randomized boundaries checked
// against a priority-rule model with a tracked NMI mask.

module tb_zet_int_sched;

   localparam int unsigned VEC_TMO = 15;
   localparam logic [7:0]  DEF_VEC = 8'hFF;
`ifdef ZET_NMI_MASK_EN
   localparam bit MASK_EN = 1'b1;
`else
   localparam bit MASK_EN = 1'b0;
`endif

   logic       clk, rst_n, exec_st, end_seq, block, rep, div_exc;
   logic       tflm, iflm, iflss, intr, nmir, iret, vec_vld;
   logic [7:0] vec_in;
   logic [2:0] sel;
   logic [7:0] vector;
   logic       inta, nmia, busy;

   int tests = 0;
   int fails = 0;
   bit mask_m = 1'b0;

   zet_int_sched #(.VEC_TMO(VEC_TMO), .DEF_VEC(DEF_VEC)) dut (
      .clk(clk), .rst_n(rst_n), .exec_st(exec_st), .end_seq(end_seq), .block(block),
      .rep(rep), .div_exc(div_exc), .tflm(tflm), .iflm(iflm), .iflss(iflss),
      .intr(intr), .nmir(nmir), .iret(iret), .vec_vld(vec_vld), .vec_in(vec_in),
      .sel(sel), .vector(vector), .inta(inta), .nmia(nmia), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] exp_sel(input logic dv, tf, nm, ir, ifm, ss, rp, msk);
      if (dv) return 3'd1;
      if (!ss) return 3'd0;
      if (tf) return 3'd2;
      if (nm && !msk) return 3'd3;
      if (ir && ifm) return rp ? 3'd5 : 3'd4;
      return 3'd0;
   endfunction

   task automatic pulse_iret();
      iret = 1'b1;
      tick();
      iret = 1'b0;
      mask_m = 1'b0;
      chk("iret_idle_busy", 8'(busy), 8'd0);
   endtask

   task automatic finish_seq();
      end_seq = 1'b1;
      tick();
      end_seq = 1'b0;
      chk("end_busy", 8'(busy), 8'd0);
      chk("end_sel", 8'(sel), 8'd0);
   endtask

   // d: cycle index after the inta cycle whose edge samples vec_vld (0 = PIC silent)
   task automatic serve(input logic dv, tf, nm, ir, ifm, ss, rp, input int d, input logic [7:0] vreq);
      logic [2:0] es;
      logic [7:0] v0, v, ev;
      int         first, ek;
      es = exp_sel(dv, tf, nm, ir, ifm, ss, rp, mask_m);
      tflm = tf; nmir = nm; intr = ir; iflm = ifm; iflss = ss; rep = rp;
      div_exc = dv;
      end_seq = 1'b1;
      tick();
      end_seq = 1'b0;
      div_exc = 1'b0;
      chk("sel_boundary", 8'(sel), 8'(es));
      chk("busy_boundary", 8'(busy), 8'(es != 3'd0));
      chk("inta_boundary", 8'(inta), 8'(es >= 3'd4));
      chk("nmia_boundary", 8'(nmia), 8'(es == 3'd3));
      if (es == 3'd3 && MASK_EN) mask_m = 1'b1;
      if (es == 3'd0) return;
      if (es >= 3'd4) begin
         v0 = vector;
         v  = (vreq != 8'd0) ? vreq : 8'($urandom_range(1, 254));
         if (v == v0) v = (v == 8'd254) ? 8'd1 : v + 8'd1;
         first = 0;
         for (int k = 1; k <= int'(VEC_TMO) + 4; k++) begin
            vec_vld = (k == d);
            vec_in  = (k == d) ? v : 8'($urandom);
            tick();
            vec_vld = 1'b0;
            if (first == 0 && vector != v0) first = k;
            chk("inta_one_shot", 8'(inta), 8'd0);
            chk("sel_held_irq", 8'(sel), 8'(es));
         end
         ek = (d >= 2 && d <= int'(VEC_TMO) + 1) ? d : int'(VEC_TMO) + 1;
         ev = (d >= 2 && d <= int'(VEC_TMO) + 1) ? v : DEF_VEC;
         chk("vector_irq", vector, ev);
         if (ev != v0) chk("vector_latency", 8'(first), 8'(ek));
      end else begin
         chk("vector_fixed", vector, (es == 3'd1) ? 8'd0 : (es == 3'd2) ? 8'd1 : 8'd2);
         tick();
         chk("nmia_one_shot", 8'(nmia), 8'd0);
         chk("sel_held_run", 8'(sel), 8'(es));
      end
      finish_seq();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_sel"}, 8'(sel), 8'd0);
      chk({tag, "_vector"}, vector, 8'd0);
      chk({tag, "_inta"}, 8'(inta), 8'd0);
      chk({tag, "_nmia"}, 8'(nmia), 8'd0);
      chk({tag, "_busy"}, 8'(busy), 8'd0);
   endtask

   initial begin
      rst_n = 1'b0; exec_st = 1'b1; end_seq = 1'b0; block = 1'b0; rep = 1'b0;
      div_exc = 1'b0; tflm = 1'b0; iflm = 1'b0; iflss = 1'b1; intr = 1'b0;
      nmir = 1'b0; iret = 1'b0; vec_vld = 1'b0; vec_in = 8'd0;
      #23;
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();
      chk_all_zero("post_reset");

      // IRQ answered, IRQ timeout, expiry-cycle race, late answer, answer during ACK
      serve(0, 0, 0, 1, 1, 1, 0, 3, 8'h08);
      serve(0, 0, 0, 1, 1, 1, 0, 0, 8'h00);
      serve(0, 0, 0, 1, 1, 1, 1, int'(VEC_TMO) + 1, 8'h00);
      serve(0, 0, 0, 1, 1, 1, 0, int'(VEC_TMO) + 2, 8'h00);
      serve(0, 0, 0, 1, 1, 1, 1, 1, 8'h00);

      // NMI and IRQ together, then IRQ alone
      serve(0, 0, 1, 1, 1, 1, 0, 3, 8'h00);
      serve(0, 0, 0, 1, 1, 1, 0, 3, 8'h00);

      // SS shadow defers, then TRAP beats NMI
      serve(0, 1, 1, 0, 0, 0, 0, 0, 8'h00);
      serve(0, 1, 1, 0, 0, 1, 0, 0, 8'h00);

      // DIV pulse inside a 3-cycle stall
      tflm = 1'b0; nmir = 1'b0; intr = 1'b0;
      block = 1'b1;
      tick();
      chk("blk_sel_1", 8'(sel), 8'd0);
      div_exc = 1'b1;
      tick();
      div_exc = 1'b0;
      chk("blk_sel_2", 8'(sel), 8'd0);
      chk("blk_busy_2", 8'(busy), 8'd0);
      tick();
      chk("blk_sel_3", 8'(sel), 8'd0);
      block = 1'b0;
      tick();
      chk("div_sel", 8'(sel), 8'd1);
      chk("div_busy", 8'(busy), 8'd1);
      chk("div_vector", vector, 8'd0);
      chk("div_nmia", 8'(nmia), 8'd0);
      finish_seq();

      // DIV pre-empts a TRAP boundary in the same cycle
      serve(1, 1, 0, 0, 0, 1, 0, 0, 8'h00);

      // held NMI across boundaries, with and without the mask
      pulse_iret();
      serve(0, 0, 1, 0, 0, 1, 0, 0, 8'h00);
      serve(0, 0, 1, 0, 0, 1, 0, 0, 8'h00);
      pulse_iret();
      serve(0, 0, 1, 0, 0, 1, 0, 0, 8'h00);
      pulse_iret();

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(3) == 0) pulse_iret();
         serve($urandom_range(7) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0,
               $urandom_range(1) == 0, $urandom_range(3) != 0, $urandom_range(4) != 0,
               $urandom_range(1) == 0, int'($urandom_range(0, 20)), 8'h00);
      end

      // asynchronous reset during VWAIT, then during ACK
      tflm = 1'b0; nmir = 1'b0; intr = 1'b1; iflm = 1'b1; iflss = 1'b1; rep = 1'b0;
      end_seq = 1'b1;
      tick();
      end_seq = 1'b0;
      chk("pre_rst_inta", 8'(inta), 8'd1);
      tick();
      tick();
      intr = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("rst_vwait");
      rst_n = 1'b1;
      mask_m = 1'b0;
      intr = 1'b1;
      end_seq = 1'b1;
      tick();
      end_seq = 1'b0;
      intr = 1'b0;
      chk("ack_inta", 8'(inta), 8'd1);
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("rst_ack");
      #1 rst_n = 1'b1;
      tick();
      chk_all_zero("after_rst");
      serve(0, 0, 0, 1, 1, 1, 0, 3, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
